// File: rtl/jtcop_pkg.sv
// Shared types and constants for the object-RAM copy engine.
package jtcop_pkg;

   // Default copy length is 2**COPY_AW words
   localparam int unsigned COPY_AW = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_COPY  = 2'd2,
      ST_FLUSH = 2'd3
   } dma_state_t;

endpackage

// File: rtl/jtcop_obj_dma.sv
// Copies the whole object RAM into the object line-buffer RAM on a CPU strobe.
// Optional JTCOP_OBJ_DMA_VBL_EN holds a requested copy until vertical blank.
module jtcop_obj_dma
   import jtcop_pkg::*;
#(
   parameter int unsigned AW = COPY_AW,
   parameter int unsigned DW = 16
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          obj_copy,
   input  logic          vblank,
   output logic [AW-1:0] src_addr,
   input  logic [DW-1:0] src_data,
   output logic [AW-1:0] dst_addr,
   output logic [DW-1:0] dst_data,
   output logic          dst_we,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] LAST_ADDR = '1;

   dma_state_t st;
   logic       copy_l;
   logic       pending;
   logic       we_q;
   logic       done_q;
   logic       req;

   assign req = obj_copy & ~copy_l;

   // The source RAM answers one enabled cycle late, so its data lines up with dst_addr
   assign dst_we   = we_q & cen;
   assign dst_data = dst_we ? src_data : '0;
   assign done     = done_q & cen;

`ifndef JTCOP_OBJ_DMA_VBL_EN
   logic unused_vblank;
   assign unused_vblank = vblank;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= ST_IDLE;
         copy_l   <= 1'b1;
         pending  <= 1'b0;
         src_addr <= '0;
         dst_addr <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         busy     <= 1'b0;
      end else if (cen) begin
         copy_l <= obj_copy;
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (req || pending) begin
                  pending  <= 1'b0;
                  busy     <= 1'b1;
                  src_addr <= '0;
`ifdef JTCOP_OBJ_DMA_VBL_EN
                  st       <= vblank ? ST_COPY : ST_WAIT;
`else
                  st       <= ST_COPY;
`endif
               end else begin
                  busy <= 1'b0;
               end
            end
`ifdef JTCOP_OBJ_DMA_VBL_EN
            ST_WAIT: begin
               if (req) pending <= 1'b1;
               if (vblank) begin
                  src_addr <= '0;
                  st       <= ST_COPY;
               end
            end
`endif
            ST_COPY: begin
               if (req) pending <= 1'b1;
               we_q     <= 1'b1;
               dst_addr <= src_addr;
               // Hold the read address on the last word so nothing wraps to word 0
               if (src_addr == LAST_ADDR) begin
                  st <= ST_FLUSH;
               end else begin
                  src_addr <= src_addr + AW'(1);
               end
            end
            ST_FLUSH: begin
               done_q  <= 1'b1;
               busy    <= pending | req;
               pending <= pending | req;
               st      <= ST_IDLE;
            end
            default: begin
               st   <= ST_IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Randomized bench for jtcop_obj_dma against a cycle-count reference model.
// Define JTCOP_OBJ_DMA_VBL_EN here as well to exercise the vblank-gated build.
module tb_jtcop_obj_dma;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;
   localparam int N = 1 << AW;

   logic          rst, clk, cen, obj_copy, vblank;
   logic [AW-1:0] src_addr, dst_addr;
   logic [DW-1:0] src_data, dst_data;
   logic          dst_we, busy, done;

   int checks, failures;
   int cyc;
   int cen_mode;

   logic [DW-1:0] src_mem [N];
   logic [DW-1:0] dst_mem [N];

   // reference model state: copies are counted in enabled cycles from the request
   bit m_hist, m_act, m_wait, m_pend;
   int m_n, m_started;
   int we_cnt, done_cnt, req_cyc, done_cyc;
   bit req_seen;

   jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
      .rst      (rst),
      .clk      (clk),
      .cen      (cen),
      .obj_copy (obj_copy),
      .vblank   (vblank),
      .src_addr (src_addr),
      .src_data (src_data),
      .dst_addr (dst_addr),
      .dst_data (dst_data),
      .dst_we   (dst_we),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (cen) src_data <= src_mem[src_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
      end
   endtask

   task automatic model_start();
      m_n = 0;
      m_started++;
`ifdef JTCOP_OBJ_DMA_VBL_EN
      m_wait = !vblank;
`else
      m_wait = 1'b0;
`endif
   endtask

   task automatic model_cycle();
      bit req, e_busy, e_we, e_done, gate;
      if (rst) begin
         m_hist = 1'b1; m_act = 1'b0; m_wait = 1'b0; m_pend = 1'b0; m_n = 0;
         check("rst_busy",     32'(busy),     0);
         check("rst_done",     32'(done),     0);
         check("rst_dst_we",   32'(dst_we),   0);
         check("rst_src_addr", 32'(src_addr), 0);
         check("rst_dst_addr", 32'(dst_addr), 0);
         check("rst_dst_data", 32'(dst_data), 0);
      end else begin
         if (dst_we) begin
            we_cnt++;
            dst_mem[dst_addr] = dst_data;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (!cen) begin
            check("we_cen_off",   32'(dst_we), 0);
            check("done_cen_off", 32'(done),   0);
         end else begin
            req    = obj_copy && !m_hist;
            m_hist = obj_copy;
`ifdef JTCOP_OBJ_DMA_VBL_EN
            gate = vblank;
`else
            gate = 1'b1;
`endif
            if (m_act && !m_wait) m_n++;
            e_busy = m_act && (m_wait || (m_n >= 1 && m_n <= N + 1) || (m_n == N + 2 && m_pend));
            e_we   = m_act && !m_wait && m_n >= 2 && m_n <= N + 1;
            e_done = m_act && !m_wait && m_n == N + 2;
            check("busy",   32'(busy),   32'(e_busy));
            check("dst_we", 32'(dst_we), 32'(e_we));
            check("done",   32'(done),   32'(e_done));
            if (e_we) begin
               check("dst_addr", 32'(dst_addr), 32'(m_n - 2));
               check("dst_data", 32'(dst_data), 32'(src_mem[m_n - 2]));
            end
            if (!m_act) begin
               if (req) begin
                  m_act = 1'b1;
                  model_start();
                  if (!req_seen) begin
                     req_seen = 1'b1;
                     req_cyc  = cyc;
                  end
               end
            end else if (m_wait) begin
               if (req) m_pend = 1'b1;
               if (gate) begin
                  m_wait = 1'b0;
                  m_n    = 0;
               end
            end else if (m_n < N + 2) begin
               if (req) m_pend = 1'b1;
            end else begin
               if (m_pend || req) begin
                  m_pend = 1'b0;
                  model_start();
               end else begin
                  m_act = 1'b0;
               end
            end
         end
      end
   endtask

   // Finish the current cycle (sample at negedge) and set up the next one
   task automatic step();
      @(negedge clk);
      model_cycle();
      cyc++;
      @(posedge clk);
      #1;
      case (cen_mode)
         0:       cen = 1'b1;
         1:       cen = ~cen;
         default: begin
            cen    = ($urandom_range(3) != 0);
            vblank = 1'($urandom_range(1));
         end
      endcase
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (!m_act && !busy) break;
      end
      check("idle_reached", {30'd0, m_act, busy}, 0);
   endtask

   task automatic pulse_req();
      bit got;
      got = 1'b0;
      obj_copy = 1'b1;
      for (int i = 0; i < 64 && !got; i++) begin
         got = cen;
         step();
      end
      obj_copy = 1'b0;
   endtask

   task automatic clear_stats();
      we_cnt = 0; done_cnt = 0; req_cyc = 0; done_cyc = 0; req_seen = 1'b0; m_started = 0;
   endtask

   task automatic fill_src(input logic [DW-1:0] key);
      for (int n = 0; n < N; n++) src_mem[n] = DW'(n) ^ key;
   endtask

   task automatic clear_dst(input logic [DW-1:0] val);
      for (int n = 0; n < N; n++) dst_mem[n] = val;
   endtask

   task automatic dst_compare(input string tag);
      int bad;
      bad = 0;
      for (int n = 0; n < N; n++) if (dst_mem[n] !== src_mem[n]) bad++;
      check(tag, 32'(bad), 0);
   endtask

   initial begin
      int bad, nreq;
      checks = 0; failures = 0; cyc = 0; cen_mode = 0;
      rst = 1'b1; cen = 1'b1; obj_copy = 1'b1; vblank = 1'b1;
      m_hist = 1'b1; m_act = 1'b0; m_wait = 1'b0; m_pend = 1'b0; m_n = 0;
      clear_stats();
      fill_src(16'hA5A5);
      clear_dst('0);

      // obj_copy held high across reset release must not start a copy
      run(3);
      rst = 1'b0;
      run(6);
      obj_copy = 1'b0;
      run(3);
      check("no_copy_after_rst", 32'(we_cnt + done_cnt), 0);

      // single copy, fixed pattern
      clear_stats();
      pulse_req();
      run_until_idle(3000);
      check("t1_we_cnt",   32'(we_cnt),            32'(N));
      check("t1_done_cnt", 32'(done_cnt),          1);
      check("t1_done_lat", 32'(done_cyc - req_cyc), 32'(N + 2));
      dst_compare("t1_dst");

      // held strobe gives one copy
      fill_src(DW'($urandom)); clear_dst('0); clear_stats();
      obj_copy = 1'b1;
      run(50);
      obj_copy = 1'b0;
      run_until_idle(3000);
      check("t2_we_cnt",   32'(we_cnt),   32'(N));
      check("t2_done_cnt", 32'(done_cnt), 1);
      dst_compare("t2_dst");

      // second request mid-copy queues a back-to-back copy
      fill_src(DW'($urandom)); clear_dst('0); clear_stats();
      pulse_req();
      for (int i = 0; i < 3000 && we_cnt < 300; i++) step();
      check("t3_words_at_req", 32'(we_cnt), 300);
      pulse_req();
      run_until_idle(5000);
      check("t3_we_cnt",   32'(we_cnt),   32'(2 * N));
      check("t3_done_cnt", 32'(done_cnt), 2);
      dst_compare("t3_dst");

      // alternating clock enable
      fill_src(16'hA5A5); clear_dst('0); clear_stats();
      cen_mode = 1;
      pulse_req();
      run_until_idle(6000);
      check("t4_done_lat", 32'(done_cyc - req_cyc), 32'(2 * N + 4));
      check("t4_we_cnt",   32'(we_cnt),             32'(N));
      dst_compare("t4_dst");
      cen_mode = 0;
      cen = 1'b1;
      run(2);

      // reset mid-copy aborts, then a full copy still works
      fill_src(DW'($urandom)); clear_dst(16'hDEAD); clear_stats();
      pulse_req();
      for (int i = 0; i < 3000 && we_cnt < 500; i++) step();
      check("t5_words_at_rst", 32'(we_cnt), 500);
      rst = 1'b1;
      run(3);
      bad = 0;
      for (int n = 0; n < N; n++)
         if (dst_mem[n] !== ((n < 500) ? src_mem[n] : 16'hDEAD)) bad++;
      check("t5_partial_dst", 32'(bad), 0);
      rst = 1'b0;
      run(4);
      check("t5_no_done", 32'(done_cnt), 0);
      clear_stats();
      pulse_req();
      run_until_idle(3000);
      check("t5_we_cnt",   32'(we_cnt),   32'(N));
      check("t5_done_cnt", 32'(done_cnt), 1);
      dst_compare("t5_dst");

`ifdef JTCOP_OBJ_DMA_VBL_EN
      // request outside vblank waits for it
      fill_src(DW'($urandom)); clear_dst('0); clear_stats();
      vblank = 1'b0;
      pulse_req();
      run(200);
      check("vbl_no_write_yet", 32'(we_cnt), 0);
      vblank = 1'b1;
      run_until_idle(3000);
      check("vbl_we_cnt",   32'(we_cnt),   32'(N));
      check("vbl_done_cnt", 32'(done_cnt), 1);
      dst_compare("vbl_dst");
`endif

      // random enables, request spacing and vblank
      for (int it = 0; it < 3; it++) begin
         fill_src(DW'($urandom)); clear_dst('0); clear_stats();
         cen_mode = 2;
         nreq = $urandom_range(3, 1);
         for (int r = 0; r < nreq; r++) begin
            run($urandom_range(1200, 1));
            pulse_req();
         end
         run_until_idle(12000);
         check("rnd_done_cnt", 32'(done_cnt), 32'(m_started));
         dst_compare("rnd_dst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jtcop_obj_dma.md
JTCOP_OBJ_DMA -- requirements
Module: jtcop_obj_dma

Interface
REQ-001 Parameter AW, default 10: word-address width; copy length is 2**AW words.
REQ-002 Parameter DW, default 16: data word width.
REQ-003 rst  input  1  asynchronous reset, active high.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 cen  input  1  clock enable; state, counters and outputs advance only when cen=1.
REQ-006 obj_copy  input  1  level strobe from the address decoder (CPU write to the object-copy register).
REQ-007 vblank  input  1  vertical blank level from video timing.
REQ-008 src_addr  output  AW  object RAM read address.
REQ-009 src_data  input  DW  object RAM read data, valid one enabled cycle after src_addr.
REQ-010 dst_addr  output  AW  object line-buffer RAM write address.
REQ-011 dst_data  output  DW  write data.
REQ-012 dst_we  output  1  write enable, one enabled cycle per word.
REQ-013 busy  output  1  copy in progress or pending.
REQ-014 done  output  1  one-enabled-cycle pulse after the last word is written.

Function
REQ-015 A copy request is the rising edge of obj_copy sampled on cen; holding obj_copy high does not generate further requests.
REQ-016 States: IDLE, WAIT, COPY, FLUSH.
REQ-017 IDLE -> COPY on a request (WAIT is skipped unless REQ-030 applies); src_addr=0 in the first COPY cycle.
REQ-018 COPY: src_addr increments by 1 each enabled cycle; at src_addr=2**AW-1 the next state is FLUSH.
REQ-019 From the second COPY cycle on, dst_we=1, dst_addr=src_addr-1, dst_data=src_data (one-cycle pipeline).
REQ-020 FLUSH: writes the final word (dst_addr=2**AW-1), then returns to IDLE with done=1 for one enabled cycle.
REQ-021 Timing, cen held high, request sampled at cycle t: busy=1 from t+1 through t+2**AW+1; dst_we=1 for exactly 2**AW cycles, t+2 through t+2**AW+1; done=1 at t+2**AW+2.
REQ-022 Address arithmetic is unsigned modulo 2**AW; there is no write beyond word 2**AW-1 and no wrap to word 0.
REQ-023 A request during WAIT, COPY or FLUSH sets a one-deep pending flag; further requests while pending are discarded.
REQ-024 On return to IDLE with pending set: done still pulses, pending clears, and a new copy starts the next enabled cycle; busy stays high throughout.
REQ-025 cen=0 freezes all state, addresses and dst_we; dst_we is qualified with cen so no write is issued on a disabled cycle.
REQ-026 done and dst_we are never high in the same cycle.

Reset
REQ-027 While rst=1: state=IDLE, pending=0, src_addr=0, dst_addr=0, dst_data=0, dst_we=0, busy=0, done=0, edge-detector history=1.
REQ-028 Edge-detector history resets to 1, so an obj_copy held high through reset release does not start a copy.
REQ-029 Reset mid-copy aborts immediately; the partial destination contents are left unchanged; no done pulse is issued.

Configuration
REQ-030 Macro JTCOP_OBJ_DMA_VBL_EN defined: a request moves IDLE -> WAIT; WAIT -> COPY on the first enabled cycle with vblank=1, including the request cycle itself when vblank is already high; busy=1 while in WAIT.
REQ-031 Macro JTCOP_OBJ_DMA_VBL_EN undefined: the WAIT state and vblank logic are not compiled in; vblank is ignored; timing is as in REQ-021.

Structure
REQ-032 Shared package jtcop_pkg holds the state enumeration type and the default copy-length constant.
REQ-033 Single module; no sub-modules. The edge detector is inline.

Verification
REQ-034 AW=10, cen=1, src RAM word n = n^16'hA5A5, obj_copy pulsed at t -> dst holds 1024 matching words; dst_we asserted for 1024 cycles; done pulses at t+1026.
REQ-035 obj_copy held high for 50 cycles -> exactly one copy and one done pulse.
REQ-036 Second request at word 300 of an active copy -> two back-to-back copies; busy never drops between them; two done pulses.
REQ-037 cen toggled 1,0,1,0 throughout -> same destination contents as REQ-034; dst_we never high while cen=0; done at t+2052.
REQ-038 rst asserted after word 500 -> all outputs 0 at once; no done pulse; a later request performs a full copy.
REQ-039 JTCOP_OBJ_DMA_VBL_EN defined, request with vblank=0, vblank rises 200 cycles later -> busy high from t+1; first dst_we 1 cycle after the first COPY cycle following the vblank rise.
